motor_cmd_conditioner: RTL and testbench
========================================

MOTOR_CMD_CONDITIONER -- requirements
Module: motor_cmd_conditioner

Interface
REQ-001 The block SHALL have parameter NCMD, default 7, number of command channels.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2 (min 2), synchroniser flop depth.
REQ-003 The block SHALL have parameter DEBOUNCE_CYC, default 1000 (min 1), stable cycles required before a level change is accepted.
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 5000 (min 1), cycles from rise to first auto-repeat pulse.
REQ-005 The block SHALL have parameter REPEAT_RATE, default 1000 (min 1), cycles between subsequent auto-repeat pulses.
REQ-006 The block SHALL have parameter REPEAT_MASK, default 7'b0001111, channels with auto-repeat.
REQ-007 The block SHALL have parameter STOP_BIT, default 5, index of the priority-stop channel.
REQ-008 The block SHALL have parameter ACTIVE_LOW, default 0; when 1, raw inputs are active-low.
REQ-009 The block SHALL have port clkI, input, 1, clock (10 MHz nominal).
REQ-010 The block SHALL have port nRstI, input, 1, reset, asynchronous, active-low.
REQ-011 The block SHALL have port cmdI, input, NCMD, raw asynchronous command inputs.
REQ-012 The block SHALL have port levelO, output, NCMD, debounced active-high command level.
REQ-013 The block SHALL have port riseO, output, NCMD, one-cycle pulse on levelO 0->1.
REQ-014 The block SHALL have port fallO, output, NCMD, one-cycle pulse on levelO 1->0.
REQ-015 The block SHALL have port cmdPulseO, output, NCMD, one-cycle command pulses (rise plus auto-repeat), stop-gated.

Function
REQ-016 Each cmdI bit SHALL be XORed with ACTIVE_LOW, then passed through a SYNC_STAGES-deep flop chain; no raw input SHALL reach any other logic.
REQ-017 Per channel, a debounce counter SHALL increment each cycle the synchroniser output differs from levelO and SHALL clear whenever they are equal.
REQ-018 When the counter would reach DEBOUNCE_CYC, levelO SHALL toggle on that edge and the counter SHALL clear; total latency from first edge sampling a stable new value to levelO change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYC edges.
REQ-019 Any input pulse shorter than DEBOUNCE_CYC cycles (post-sync) SHALL produce no levelO change.
REQ-020 riseO/fallO SHALL assert on the same edge levelO changes, for exactly one cycle.
REQ-021 For channels in REPEAT_MASK, a repeat counter SHALL start at rise; while levelO stays 1, repeat pulses SHALL occur REPEAT_DELAY cycles after rise, then every REPEAT_RATE cycles; fall SHALL clear the counter immediately with no trailing pulse.
REQ-022 Repeat counters SHALL saturate/wrap only within their own period; held inputs SHALL repeat indefinitely without overflow artefacts.
REQ-023 cmdPulseO[i] SHALL be riseO[i] OR repeat pulse[i], registered-equivalent timing (same edge as riseO).
REQ-024 While levelO[STOP_BIT]=1, cmdPulseO of all other channels SHALL be 0 and their repeat counters held cleared; cmdPulseO[STOP_BIT] SHALL pulse on its rise only (never repeats, regardless of REPEAT_MASK).
REQ-025 On stop fall, masked channels still at level 1 SHALL restart their repeat counter with no rise pulse; first pulse REPEAT_DELAY cycles after the stop fall edge.
REQ-026 Simultaneous rise of stop and another channel on the same edge: only cmdPulseO[STOP_BIT] SHALL assert.
REQ-027 levelO/riseO/fallO SHALL be unaffected by stop gating.

Reset
REQ-028 nRstI low SHALL asynchronously clear all sync flops, debounce counters, repeat counters, levelO, riseO, fallO, cmdPulseO to 0 (inactive after polarity normalisation).
REQ-029 Reset release with an input already active SHALL yield levelO rise plus riseO/cmdPulseO after SYNC_STAGES+DEBOUNCE_CYC edges.

Verification (NCMD=7, SYNC_STAGES=2, DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-030 cmdI[6] 0->1 held 20 cycles -> levelO[6] rises at edge 6, riseO[6]/cmdPulseO[6] single pulse, no repeats; release -> levelO[6] falls 6 edges later, fallO[6] one pulse.
REQ-031 cmdI[2] high 3 cycles -> levelO, riseO, cmdPulseO remain 0.
REQ-032 cmdI[2] held 30 cycles past rise -> cmdPulseO[2] at rise+0, +10, +13, +16, +19, ...; release -> no further pulses after levelO falls.
REQ-033 cmdI[3] held, then cmdI[5] asserted -> after levelO[5] rises, cmdPulseO[3]=0; release stop -> cmdPulseO[3] resumes exactly 10 cycles after levelO[5] falls.
REQ-034 nRstI pulsed low during repeating hold of cmdI[2] -> all outputs 0 immediately; after release, levelO[2] rises after 6 edges with riseO[2].
REQ-035 ACTIVE_LOW=1, all cmdI idle high -> levelO=0 permanently; cmdI[0] driven low -> levelO[0] rises at edge 6.

Source files
------------

// File: rtl/motor_cmd_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : motor_cmd_conditioner
// Purpose  : Conditions raw asynchronous motor command inputs. Each input is
//            polarity-normalised, synchronised, debounced and edge-detected.
//            Selected channels auto-repeat while held. One channel acts as a
//            priority stop that suppresses every other command pulse.
// Ports    : clkI      - clock
//            nRstI     - asynchronous active-low reset
//            cmdI      - raw command inputs (NCMD)
//            levelO    - debounced active-high level (NCMD)
//            riseO     - one-cycle pulse on levelO 0->1 (NCMD)
//            fallO     - one-cycle pulse on levelO 1->0 (NCMD)
//            cmdPulseO - rise + auto-repeat pulses, stop-gated (NCMD)
// Revision : 1.0 - initial release
// ============================================================================
module motor_cmd_conditioner #(
  parameter int              NCMD         = 7,
  parameter int              SYNC_STAGES  = 2,
  parameter int              DEBOUNCE_CYC = 1000,
  parameter int              REPEAT_DELAY = 5000,
  parameter int              REPEAT_RATE  = 1000,
  parameter logic [NCMD-1:0] REPEAT_MASK  = 7'b0001111,
  parameter int              STOP_BIT     = 5,
  parameter bit              ACTIVE_LOW   = 1'b0
) (
  input  logic            clkI,
  input  logic            nRstI,
  input  logic [NCMD-1:0] cmdI,
  output logic [NCMD-1:0] levelO,
  output logic [NCMD-1:0] riseO,
  output logic [NCMD-1:0] fallO,
  output logic [NCMD-1:0] cmdPulseO
);

  // Counter widths sized so the largest terminal count fits.
  localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam int REP_MX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W  = (REP_MX > 1) ? $clog2(REP_MX + 1) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [NCMD-1:0] cmd_norm;
  logic [NCMD-1:0] sync_q [SYNC_STAGES];
  logic [NCMD-1:0] sync_out;
  logic [NCMD-1:0] toggle;
  logic [NCMD-1:0] level_nxt;
  logic [NCMD-1:0] rise_nxt;
  logic [NCMD-1:0] fall_nxt;
  logic [NCMD-1:0] rep_fire;
  logic [NCMD-1:0] pulse_nxt;
  logic            stop_cur;
  logic            stop_nxt;
  logic            stop_hold;

  // --------------------------------------------------------------------------
  // Polarity normalisation and synchroniser chain. The raw input feeds only
  // the first flop stage.
  // --------------------------------------------------------------------------
  assign cmd_norm = cmdI ^ {NCMD{ACTIVE_LOW}};

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= cmd_norm;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Level tracking: the new level and its edge pulses are all registered on
  // the same edge, so riseO/fallO/cmdPulseO line up with the levelO change.
  assign level_nxt = levelO ^ toggle;
  assign rise_nxt  = toggle & level_nxt;
  assign fall_nxt  = toggle & ~level_nxt;

  // Stop state as it will be after this edge, and the window (either side
  // of this edge) in which repeat counters are forced clear. Holding clear
  // on the stop-fall edge makes the first resumed pulse land exactly
  // REPEAT_DELAY cycles after that edge.
  assign stop_cur  = levelO[STOP_BIT];
  assign stop_nxt  = level_nxt[STOP_BIT];
  assign stop_hold = stop_cur | stop_nxt;

  genvar gi;
  generate
    for (gi = 0; gi < NCMD; gi++) begin : g_ch
      logic [DEB_W-1:0] deb_cnt;

      // Toggle on the edge where the counter would reach DEBOUNCE_CYC.
      assign toggle[gi] = (sync_out[gi] != levelO[gi]) && (deb_cnt == DEB_LAST);

      always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
          deb_cnt <= '0;
        end else if ((sync_out[gi] == levelO[gi]) || toggle[gi]) begin
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end

      if (REPEAT_MASK[gi] && (gi != STOP_BIT)) begin : g_rep
        logic [REP_W-1:0] rep_cnt;
        logic             rep_first_done;
        logic             rep_run;

        // Counting only while the level is 1 both before and after this
        // edge: the rise edge loads zero and the fall edge clears at once,
        // so no trailing pulse can be produced.
        assign rep_run = levelO[gi] & level_nxt[gi] & ~stop_hold;
        assign rep_fire[gi] = rep_run &
                              (rep_first_done ? (rep_cnt == RATE_LAST)
                                              : (rep_cnt == DELAY_LAST));

        always_ff @(posedge clkI or negedge nRstI) begin
          if (!nRstI) begin
            rep_cnt        <= '0;
            rep_first_done <= 1'b0;
          end else if (!rep_run) begin
            rep_cnt        <= '0;
            rep_first_done <= 1'b0;
          end else if (rep_fire[gi]) begin
            rep_cnt        <= '0;
            rep_first_done <= 1'b1;
          end else begin
            rep_cnt        <= rep_cnt + 1'b1;
          end
        end
      end else begin : g_norep
        assign rep_fire[gi] = 1'b0;
      end

      if (gi == STOP_BIT) begin : g_stop_pulse
        assign pulse_nxt[gi] = rise_nxt[gi];
      end else begin : g_cmd_pulse
        // Gated by the post-edge stop level so a rise coincident with the
        // stop rise is suppressed.
        assign pulse_nxt[gi] = (rise_nxt[gi] | rep_fire[gi]) & ~stop_nxt;
      end
    end
  endgenerate

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      levelO    <= '0;
      riseO     <= '0;
      fallO     <= '0;
      cmdPulseO <= '0;
    end else begin
      levelO    <= level_nxt;
      riseO     <= rise_nxt;
      fallO     <= fall_nxt;
      cmdPulseO <= pulse_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_cmd_conditioner
// Purpose  : Self-checking bench for motor_cmd_conditioner with small timing
//            parameters. Expected rise/fall/pulse events are queued when the
//            stimulus is applied and compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_cmd_conditioner;

  localparam int N = 7;

  logic         clk = 1'b0;
  logic         nrst;
  logic [N-1:0] cmd;
  logic [N-1:0] cmd_al;
  logic [N-1:0] level, rise, fall, pulse;
  logic [N-1:0] al_level, al_rise, al_fall, al_pulse;

  always #50 clk = ~clk;

  motor_cmd_conditioner #(
    .NCMD(N), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .REPEAT_DELAY(10),
    .REPEAT_RATE(3), .REPEAT_MASK(7'b0001111), .STOP_BIT(5), .ACTIVE_LOW(1'b0)
  ) dut (
    .clkI(clk), .nRstI(nrst), .cmdI(cmd),
    .levelO(level), .riseO(rise), .fallO(fall), .cmdPulseO(pulse)
  );

  motor_cmd_conditioner #(
    .NCMD(N), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .REPEAT_DELAY(10),
    .REPEAT_RATE(3), .REPEAT_MASK(7'b0001111), .STOP_BIT(5), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clkI(clk), .nRstI(nrst), .cmdI(cmd_al),
    .levelO(al_level), .riseO(al_rise), .fallO(al_fall), .cmdPulseO(al_pulse)
  );

  typedef struct {
    int cyc;
    int ch;
    int kind;   // 0 rise, 1 fall, 2 command pulse
  } ev_t;

  ev_t          sb[$];
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;
  int           al_on  = 32'h4000_0000;
  logic [N-1:0] exp_lvl = '0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = kind;
    sb.push_back(e);
  endtask

  // Auto-repeat pulses after a rise/restart at 'start', up to (not incl.) 'stop_excl'.
  task automatic push_repeats(input int ch, input int start, input int stop_excl);
    int p;
    p = start + 10;
    while (p < stop_excl) begin
      push(p, ch, 2);
      p += 3;
    end
  endtask

  // Advance one edge, pop the events due now and compare all outputs.
  task automatic tick();
    ev_t          rest[$];
    logic [N-1:0] er, ef, ep;
    logic [N-1:0] al_l, al_r;
    @(posedge clk);
    #1;
    cyc++;
    er = '0; ef = '0; ep = '0;
    foreach (sb[k]) begin
      if (sb[k].cyc == cyc) begin
        case (sb[k].kind)
          0:       er[sb[k].ch] = 1'b1;
          1:       ef[sb[k].ch] = 1'b1;
          default: ep[sb[k].ch] = 1'b1;
        endcase
      end else if (sb[k].cyc > cyc) begin
        rest.push_back(sb[k]);
      end
    end
    sb = rest;
    exp_lvl = (exp_lvl | er) & ~ef;
    chk("level", level, exp_lvl);
    chk("rise",  rise,  er);
    chk("fall",  fall,  ef);
    chk("pulse", pulse, ep);
    al_l = (cyc >= al_on) ? 7'b0000001 : 7'b0000000;
    al_r = (cyc == al_on) ? 7'b0000001 : 7'b0000000;
    chk("al_level", al_level, al_l);
    chk("al_rise",  al_rise,  al_r);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, level, '0);
    chk({tag, "_rise"},  rise,  '0);
    chk({tag, "_fall"},  fall,  '0);
    chk({tag, "_pulse"}, pulse, '0);
    chk({tag, "_al_level"}, al_level, '0);
    chk({tag, "_al_pulse"}, al_pulse, '0);
  endtask

  initial begin
    int t, r, r3, r5, f5, f;

    // Reset with idle inputs; outputs clear without any clock edge.
    nrst   = 1'b0;
    cmd    = '0;
    cmd_al = '1;
    #10;
    chk_all_zero("reset");
    repeat (3) tick();
    nrst = 1'b1;
    repeat (8) tick();

    // Non-repeating channel 6: single rise pulse, fall 6 edges after release.
    t = cyc;
    cmd[6] = 1'b1;
    push(t + 6, 6, 0);
    push(t + 6, 6, 2);
    wait_until(t + 20);
    t = cyc;
    cmd[6] = 1'b0;
    push(t + 6, 6, 1);
    wait_until(t + 10);

    // Glitch shorter than the debounce window on channel 2: no effect.
    cmd[2] = 1'b1;
    repeat (3) tick();
    cmd[2] = 1'b0;
    repeat (10) tick();

    // Channel 2 held 30 cycles past rise: pulses at +0, +10, +13, ...
    t = cyc;
    r = t + 6;
    cmd[2] = 1'b1;
    push(r, 2, 0);
    push(r, 2, 2);
    push_repeats(2, r, r + 36);
    push(r + 36, 2, 1);
    wait_until(r + 30);
    cmd[2] = 1'b0;
    wait_until(r + 46);

    // Channel 3 repeating, stop asserted, then released: resume 10 after stop fall.
    t  = cyc;
    r3 = t + 6;
    r5 = r3 + 17;
    cmd[3] = 1'b1;
    push(r3, 3, 0);
    push(r3, 3, 2);
    push_repeats(3, r3, r5);
    wait_until(r3 + 11);
    cmd[5] = 1'b1;
    push(r5, 5, 0);
    push(r5, 5, 2);
    wait_until(r5 + 10);
    f5 = cyc + 6;
    cmd[5] = 1'b0;
    push(f5, 5, 1);
    push_repeats(3, f5, f5 + 20);
    push(f5 + 20, 3, 1);
    wait_until(f5 + 14);
    cmd[3] = 1'b0;
    wait_until(f5 + 30);

    // Stop and masked channel 1 rise together: only the stop pulse appears.
    t = cyc;
    cmd[5] = 1'b1;
    cmd[1] = 1'b1;
    push(t + 6, 5, 0);
    push(t + 6, 5, 2);
    push(t + 6, 1, 0);
    wait_until(t + 18);
    f = cyc + 6;
    cmd[5] = 1'b0;
    cmd[1] = 1'b0;
    push(f, 5, 1);
    push(f, 1, 1);
    wait_until(f + 14);

    // Reset during a repeating hold of channel 2, input kept active.
    t = cyc;
    r = t + 6;
    cmd[2] = 1'b1;
    push(r, 2, 0);
    push(r, 2, 2);
    push_repeats(2, r, r + 14);
    wait_until(r + 14);
    nrst = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    exp_lvl = '0;
    repeat (2) tick();
    nrst = 1'b1;
    t = cyc;
    r = t + 6;
    push(r, 2, 0);
    push(r, 2, 2);
    push_repeats(2, r, r + 17);
    push(r + 17, 2, 1);
    wait_until(r + 11);
    cmd[2] = 1'b0;
    wait_until(r + 25);

    // Active-low instance: idle-high inputs stay at level 0; drive channel 0 low.
    t = cyc;
    al_on = t + 6;
    cmd_al[0] = 1'b0;
    wait_until(t + 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
